wb_completion_queue: RTL and testbench

//  Buffers completions from the long-latency units (accel, muldiv) and schedules them onto
//  the single register-file write port shared with the EX/WB path. EX owns the port by

---
 rtl/wb_completion_queue_pkg.sv | 25 ++
 rtl/wb_completion_queue_fifo.sv | 81 ++++++++
 rtl/wb_completion_queue.sv | 104 ++++++++++
 tb/tb_wb_completion_queue.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_completion_queue_pkg.sv
// Shared widths, defaults and entry layout for the write-back completion queue.
// Widths mirror the core-wide definitions; DEPTH/STARVE defaults live here too.
package wb_completion_queue_pkg;

   localparam int HART_ID_W      = 2;
   localparam int REG_ADDR_W     = 5;
   localparam int XLEN           = 32;
   localparam int WBQ_DEPTH_DEF  = 4;
   localparam int WBQ_STARVE_DEF = 8;

   // Packed as one vector {hart_id, rd, data}
   typedef struct packed {
      logic [HART_ID_W-1:0]  hart_id;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wbq_entry_t;

   // x0 is never a hazard; otherwise the entry must match both hart and register
   function automatic logic entry_hit(input wbq_entry_t e,
                                      input logic [HART_ID_W-1:0] hart,
                                      input logic [REG_ADDR_W-1:0] rs);
      return (rs != {REG_ADDR_W{1'b0}}) && (e.hart_id == hart) && (e.rd == rs);
   endfunction

endpackage

// File: rtl/wb_completion_queue_fifo.sv
// wbq_fifo: circular completion storage with per-entry valid bits so the
// pending-rd hazard compare can scan every slot in parallel.
module wbq_fifo
   import wb_completion_queue_pkg::*;
#(
   parameter int DEPTH = WBQ_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  wbq_entry_t            push_entry_i,
   input  logic                  pop_i,
   output wbq_entry_t            head_o,
   output logic                  full_o,
   output logic                  empty_o,
   input  logic [HART_ID_W-1:0]  hz_hart_i,
   input  logic [REG_ADDR_W-1:0] hz_rs1_i,
   input  logic [REG_ADDR_W-1:0] hz_rs2_i,
   output logic                  hz_hit_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   wbq_entry_t       mem_q [DEPTH];

   // Clear-then-set so a full push+pop on the same slot keeps it valid
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      valid_d  = valid_q;
      if (pop_i) begin
         rd_ptr_d          = rd_ptr_q + PTR_W'(1);
         valid_d[rd_ptr_q] = 1'b0;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (push_i) begin
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
         valid_d[wr_ptr_q] = 1'b1;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
      end
   end

   always_comb begin
      hz_hit_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         hz_hit_o = hz_hit_o | (valid_q[i] & (entry_hit(mem_q[i], hz_hart_i, hz_rs1_i) |
                                              entry_hit(mem_q[i], hz_hart_i, hz_rs2_i)));
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == (PTR_W+1)'(0));
   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/wb_completion_queue.sv
// Completion queue sharing the regfile write port with EX/WB: push mux, port arbitration,
// optional starvation guard (define WBQ_STARVE_GUARD_EN to force a drain after STARVE_LIMIT cycles).
module wb_completion_queue
   import wb_completion_queue_pkg::*;
#(
   parameter int DEPTH        = WBQ_DEPTH_DEF,
   parameter int STARVE_LIMIT = WBQ_STARVE_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  acc_valid,
   output logic                  acc_ready,
   input  logic [HART_ID_W-1:0]  acc_hart_id,
   input  logic [REG_ADDR_W-1:0] acc_rd,
   input  logic [XLEN-1:0]       acc_data,
   input  logic                  md_valid,
   output logic                  md_ready,
   input  logic [HART_ID_W-1:0]  md_hart_id,
   input  logic [REG_ADDR_W-1:0] md_rd,
   input  logic [XLEN-1:0]       md_data,
   input  logic                  ex_wb_req,
   output logic                  ex_stall,
   output logic                  wb_we,
   output logic [HART_ID_W-1:0]  wb_hart_id,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic [XLEN-1:0]       wb_data,
   input  logic [HART_ID_W-1:0]  hz_hart_id,
   input  logic [REG_ADDR_W-1:0] hz_rs1,
   input  logic [REG_ADDR_W-1:0] hz_rs2,
   output logic                  hz_hit,
   output logic                  q_empty
);

   logic       full_s, empty_s, pop_s, force_s, space_s, push_s, starve_hit_s;
   wbq_entry_t push_entry_s, head_s;

   assign force_s = full_s | starve_hit_s;
   assign pop_s   = !empty_s && (!ex_wb_req || force_s);
   assign space_s = !full_s || pop_s;

   // Accel wins the single push slot; rd==0 completions are accepted and dropped
   always_comb begin
      push_s       = 1'b0;
      push_entry_s = '0;
      if (acc_valid) begin
         push_s       = space_s && (acc_rd != {REG_ADDR_W{1'b0}});
         push_entry_s = '{hart_id: acc_hart_id, rd: acc_rd, data: acc_data};
      end else begin
         push_s       = md_valid && space_s && (md_rd != {REG_ADDR_W{1'b0}});
         push_entry_s = '{hart_id: md_hart_id, rd: md_rd, data: md_data};
      end
   end

   wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (push_s),
      .push_entry_i (push_entry_s),
      .pop_i        (pop_s),
      .head_o       (head_s),
      .full_o       (full_s),
      .empty_o      (empty_s),
      .hz_hart_i    (hz_hart_id),
      .hz_rs1_i     (hz_rs1),
      .hz_rs2_i     (hz_rs2),
      .hz_hit_o     (hz_hit)
   );

`ifdef WBQ_STARVE_GUARD_EN
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   logic [STARVE_W-1:0] starve_q, starve_d;

   // Counts cycles the head has waited; saturates at the limit
   always_comb begin
      if (empty_s || pop_s) begin
         starve_d = '0;
      end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
         starve_d = starve_q + STARVE_W'(1);
      end else begin
         starve_d = starve_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) starve_q <= '0;
      else        starve_q <= starve_d;
   end

   assign starve_hit_s = (starve_q == STARVE_W'(STARVE_LIMIT));
`else
   // Guard absent: EX may hold the port until the queue fills
   assign starve_hit_s = (STARVE_LIMIT < 0);
`endif

   assign acc_ready  = space_s;
   assign md_ready   = space_s && !acc_valid;
   assign ex_stall   = ex_wb_req && force_s && !empty_s;
   assign wb_we      = pop_s;
   assign wb_hart_id = head_s.hart_id;
   assign wb_rd      = head_s.rd;
   assign wb_data    = head_s.data;
   assign q_empty    = empty_s;

endmodule

// File: tb/tb_wb_completion_queue.sv
// Directed bench for wb_completion_queue; inputs change on negedge, outputs checked 1ns later.
module tb_wb_completion_queue;
   import wb_completion_queue_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  acc_valid, acc_ready, md_valid, md_ready;
   logic [HART_ID_W-1:0]  acc_hart_id, md_hart_id, wb_hart_id, hz_hart_id;
   logic [REG_ADDR_W-1:0] acc_rd, md_rd, wb_rd, hz_rs1, hz_rs2;
   logic [XLEN-1:0]       acc_data, md_data, wb_data;
   logic                  ex_wb_req, ex_stall, wb_we, hz_hit, q_empty;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wb_completion_queue dut (
      .clk(clk), .rst_n(rst_n),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_hart_id(acc_hart_id),
      .acc_rd(acc_rd), .acc_data(acc_data),
      .md_valid(md_valid), .md_ready(md_ready), .md_hart_id(md_hart_id),
      .md_rd(md_rd), .md_data(md_data),
      .ex_wb_req(ex_wb_req), .ex_stall(ex_stall),
      .wb_we(wb_we), .wb_hart_id(wb_hart_id), .wb_rd(wb_rd), .wb_data(wb_data),
      .hz_hart_id(hz_hart_id), .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_hit(hz_hit),
      .q_empty(q_empty)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_acc(input logic v, input logic [HART_ID_W-1:0] h,
                            input logic [REG_ADDR_W-1:0] r, input logic [XLEN-1:0] d);
      acc_valid = v; acc_hart_id = h; acc_rd = r; acc_data = d;
   endtask

   task automatic drive_md(input logic v, input logic [HART_ID_W-1:0] h,
                           input logic [REG_ADDR_W-1:0] r, input logic [XLEN-1:0] d);
      md_valid = v; md_hart_id = h; md_rd = r; md_data = d;
   endtask

   initial begin
      rst_n = 1'b0;
      drive_acc(1'b0, '0, '0, '0);
      drive_md(1'b0, '0, '0, '0);
      ex_wb_req = 1'b0;
      hz_hart_id = '0; hz_rs1 = '0; hz_rs2 = '0;
      settle();
      check("rst_q_empty",   q_empty,   1);
      check("rst_acc_ready", acc_ready, 1);
      check("rst_md_ready",  md_ready,  1);
      check("rst_wb_we",     wb_we,     0);
      check("rst_ex_stall",  ex_stall,  0);
      check("rst_hz_hit",    hz_hit,    0);
      check("rst_wb_rd",     wb_rd,     0);
      check("rst_wb_data",   wb_data,   0);
      next_cycle(); next_cycle();
      rst_n = 1'b1;

      // 1: single accel push, written the following cycle
      next_cycle();
      drive_acc(1'b1, 2'd1, 5'd5, 32'h0000_00A5);
      settle();
      check("t1_acc_ready", acc_ready, 1);
      check("t1_no_bypass", wb_we, 0);
      next_cycle();
      drive_acc(1'b0, '0, '0, '0);
      settle();
      check("t1_wb_we",   wb_we,      1);
      check("t1_wb_rd",   wb_rd,      5);
      check("t1_wb_hart", wb_hart_id, 1);
      check("t1_wb_data", wb_data,    32'hA5);
      next_cycle(); settle();
      check("t1_empty", q_empty, 1);
      check("t1_we_off", wb_we, 0);

      // 2: accel beats muldiv; muldiv follows one cycle later
      next_cycle();
      drive_acc(1'b1, 2'd0, 5'd3, 32'h11);
      drive_md(1'b1, 2'd2, 5'd4, 32'h22);
      settle();
      check("t2_acc_ready", acc_ready, 1);
      check("t2_md_ready",  md_ready,  0);
      next_cycle();
      drive_acc(1'b0, '0, '0, '0);
      settle();
      check("t2_md_ready2", md_ready, 1);
      check("t2_pop_acc",   {wb_we, wb_rd}, {1'b1, 5'd3});
      next_cycle();
      drive_md(1'b0, '0, '0, '0);
      settle();
      check("t2_pop_md",   {wb_we, wb_hart_id, wb_rd, wb_data}, {1'b1, 2'd2, 5'd4, 32'h22});
      next_cycle(); settle();
      check("t2_empty", q_empty, 1);

      // 3: EX holds the port, queue fills, full push+pop, then drains in order
      next_cycle();
      ex_wb_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive_acc(1'b1, 2'd0, 5'(10 + k), 32'(100 + k));
         settle();
         check("t3_fill_stall", ex_stall, 0);
         check("t3_fill_we",    wb_we,    0);
         next_cycle();
      end
      drive_acc(1'b1, 2'd0, 5'd14, 32'd104);
      settle();
      check("t3_full_stall", ex_stall,  1);
      check("t3_full_ready", acc_ready, 1);
      check("t3_full_pop",   {wb_we, wb_rd, wb_data}, {1'b1, 5'd10, 32'd100});
      next_cycle();
      drive_acc(1'b0, '0, '0, '0);
      settle();
      check("t3_still_full", {ex_stall, wb_we, wb_rd}, {1'b1, 1'b1, 5'd11});
      next_cycle(); settle();
      check("t3_release", {ex_stall, wb_we, q_empty}, {1'b0, 1'b0, 1'b0});
      next_cycle();
      ex_wb_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         check("t3_drain", {wb_we, wb_rd, wb_data}, {1'b1, 5'(12 + k), 32'(102 + k)});
         next_cycle();
      end
      settle();
      check("t3_empty", q_empty, 1);

      // 4: rd==0 accepted but dropped
      next_cycle();
      drive_acc(1'b1, 2'd1, 5'd0, 32'hDEAD);
      settle();
      check("t4_ready", acc_ready, 1);
      next_cycle();
      drive_acc(1'b0, '0, '0, '0);
      settle();
      check("t4_empty", q_empty, 1);
      check("t4_no_we", wb_we,   0);

      // 5: starvation behaviour with EX holding the port
      next_cycle();
      ex_wb_req = 1'b1;
      drive_acc(1'b1, 2'd3, 5'd9, 32'h99);
      next_cycle();
      drive_acc(1'b0, '0, '0, '0);
`ifdef WBQ_STARVE_GUARD_EN
      for (int k = 0; k < 8; k++) begin
         settle();
         check("t5_wait", {ex_stall, wb_we}, 2'b00);
         next_cycle();
      end
      settle();
      check("t5_forced", {ex_stall, wb_we, wb_rd}, {1'b1, 1'b1, 5'd9});
      next_cycle(); settle();
      check("t5_empty", q_empty, 1);
      ex_wb_req = 1'b0;
`else
      for (int k = 0; k < 12; k++) begin
         settle();
         check("t5_starved", {ex_stall, wb_we}, 2'b00);
         next_cycle();
      end
      ex_wb_req = 1'b0;
      settle();
      check("t5_drain", {wb_we, wb_rd}, {1'b1, 5'd9});
      next_cycle(); settle();
      check("t5_empty", q_empty, 1);
`endif

      // 6: hazard lookup, then async reset clears everything
      next_cycle();
      ex_wb_req = 1'b1;
      drive_acc(1'b1, 2'd0, 5'd7, 32'h77);
      next_cycle();
      drive_acc(1'b0, '0, '0, '0);
      hz_hart_id = 2'd0; hz_rs1 = 5'd1; hz_rs2 = 5'd7;
      settle();
      check("t6_hit_rs2", hz_hit, 1);
      hz_hart_id = 2'd1; hz_rs1 = 5'd7; hz_rs2 = 5'd0;
      settle();
      check("t6_other_hart", hz_hit, 0);
      hz_hart_id = 2'd0; hz_rs1 = 5'd0; hz_rs2 = 5'd0;
      settle();
      check("t6_rs_zero", hz_hit, 0);
      hz_rs1 = 5'd7;
      settle();
      check("t6_hit_rs1", hz_hit, 1);
      rst_n = 1'b0;
      settle();
      check("t6_rst_hit",   hz_hit,    0);
      check("t6_rst_empty", q_empty,   1);
      check("t6_rst_we",    wb_we,     0);
      check("t6_rst_ready", acc_ready, 1);
      next_cycle();
      rst_n = 1'b1;
      ex_wb_req = 1'b0;
      next_cycle(); settle();
      check("t6_after_rst", {wb_we, q_empty, hz_hit}, {1'b0, 1'b1, 1'b0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
